ad7357_sampler: RTL and testbench

AD7357_SAMPLER -- requirements
Module: ad7357_sampler

---
 rtl/ad7357_sampler.sv | 133 +++++++++++++
 tb/tb_ad7357_sampler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7357_sampler.sv
// Dual-channel AD7357 serial sampler: CS_n framing, SCLK-enable request and 14-bit capture.
// Optional sticky start-while-busy flag enabled by defining AD7357_SAMPLER_OVERRUN_EN.
module ad7357_sampler #(
  parameter int unsigned CS_SETUP_CYC = 1,
  parameter int unsigned SAMPLE_DELAY = 2,
  parameter int unsigned QUIET_CYC    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_adc_sdata_a,
  input  logic        i_adc_sdata_b,
  output logic        o_adc_cs_n,
  output logic        o_ctl_cken,
  output logic        o_busy,
  output logic [13:0] o_data_a,
  output logic [13:0] o_data_b,
  output logic        o_valid,
  output logic        o_overrun
);

  typedef enum logic [1:0] {StIdle, StCssu, StShift, StQuiet} state_e;

  localparam logic [4:0] CssuLast  = 5'(CS_SETUP_CYC - 1);
  localparam logic [4:0] FirstCap  = 5'(SAMPLE_DELAY);
  localparam logic [4:0] LastCap   = 5'(SAMPLE_DELAY + 15);
  localparam logic [4:0] QuietLast = 5'(QUIET_CYC - 1);
  localparam logic [4:0] CkenCyc   = 5'd16;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [13:0] shift_a_q, shift_b_q;
  logic [13:0] data_a_q, data_b_q;
  logic        valid_q;
  logic        capture, last_cap;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt counts cycles within the current state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (i_start) state_d = StCssu;
      end
      StCssu: begin
        if (cnt_q == CssuLast) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (cnt_q == LastCap) begin
          state_d = (QUIET_CYC == 0) ? StIdle : StQuiet;
          cnt_d   = '0;
        end
      end
      StQuiet: begin
        if (cnt_q == QuietLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_adc_cs_n = !((state_q == StCssu) || (state_q == StShift));
    o_busy     = (state_q != StIdle);
    o_ctl_cken = (state_q == StShift) && (cnt_q < CkenCyc);
  end

  assign capture  = (state_q == StShift) && (cnt_q >= FirstCap);
  assign last_cap = (state_q == StShift) && (cnt_q == LastCap);

  // The two leading zeros fall off the top of the 14-bit shifters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_a_q <= '0;
      shift_b_q <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= last_cap;
      if (capture) begin
        shift_a_q <= {shift_a_q[12:0], i_adc_sdata_a};
        shift_b_q <= {shift_b_q[12:0], i_adc_sdata_b};
      end
      if (last_cap) begin
        data_a_q <= {shift_a_q[12:0], i_adc_sdata_a};
        data_b_q <= {shift_b_q[12:0], i_adc_sdata_b};
      end
    end
  end

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;
  assign o_valid  = valid_q;

`ifdef AD7357_SAMPLER_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      overrun_q <= 1'b0;
    end else if (i_start && (state_q != StIdle)) begin
      overrun_q <= 1'b1;
    end
  end

  assign o_overrun = overrun_q;
`else
  assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_ad7357_sampler.sv
// Directed bench for ad7357_sampler: default instance plus a CS_SETUP_CYC=3/SAMPLE_DELAY=4 one.
module tb_ad7357_sampler;

  localparam logic [15:0] PatA1 = 16'h2AAA;
  localparam logic [15:0] PatB1 = 16'h1555;
  localparam logic [15:0] PatA2 = 16'h329D;
  localparam logic [15:0] PatB2 = 16'h0F0F;
`ifdef AD7357_SAMPLER_OVERRUN_EN
  localparam logic ExpOvr = 1'b1;
`else
  localparam logic ExpOvr = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start2;
  logic        sda, sdb, sda2, sdb2;
  logic        cs_n, cken, busy, valid, ovr;
  logic        cs_n2, cken2, busy2, valid2, ovr2;
  logic [13:0] data_a, data_b, data_a2, data_b2;

  int checks = 0;
  int failures = 0;

  ad7357_sampler u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_adc_sdata_a (sda),
    .i_adc_sdata_b (sdb),
    .o_adc_cs_n    (cs_n),
    .o_ctl_cken    (cken),
    .o_busy        (busy),
    .o_data_a      (data_a),
    .o_data_b      (data_b),
    .o_valid       (valid),
    .o_overrun     (ovr)
  );

  ad7357_sampler #(
    .CS_SETUP_CYC (3),
    .SAMPLE_DELAY (4),
    .QUIET_CYC    (2)
  ) u_dut2 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start2),
    .i_adc_sdata_a (sda2),
    .i_adc_sdata_b (sdb2),
    .o_adc_cs_n    (cs_n2),
    .o_ctl_cken    (cken2),
    .o_busy        (busy2),
    .o_data_a      (data_a2),
    .o_data_b      (data_b2),
    .o_valid       (valid2),
    .o_overrun     (ovr2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC models: bit k presented during cycle S+delay+k, S being the first cken cycle
  initial begin
    int  c;
    logic prev;
    c = 100; prev = 1'b0; sda = 1'b0; sdb = 1'b0;
    forever begin
      @(negedge clk);
      if (cken && !prev) c = 0; else c++;
      prev = cken;
      if (c >= 2 && c < 18) begin
        sda = PatA1[15 - (c - 2)];
        sdb = PatB1[15 - (c - 2)];
      end else begin
        sda = 1'b0;
        sdb = 1'b0;
      end
    end
  end

  initial begin
    int  c;
    logic prev;
    c = 100; prev = 1'b0; sda2 = 1'b0; sdb2 = 1'b0;
    forever begin
      @(negedge clk);
      if (cken2 && !prev) c = 0; else c++;
      prev = cken2;
      if (c >= 4 && c < 20) begin
        sda2 = PatA2[15 - (c - 4)];
        sdb2 = PatB2[15 - (c - 4)];
      end else begin
        sda2 = 1'b0;
        sdb2 = 1'b0;
      end
    end
  end

  // Observers on the default instance, sampling pre-edge values
  int hi_run = 0, gaps = 0, bad_gaps = 0, cs_falls = 0;
  int ck_run = 0, ck_max = 0, valid_cnt = 0;
  always @(posedge clk) begin
    if (cs_n) hi_run++;
    else begin
      if (hi_run > 0) begin
        gaps++;
        cs_falls++;
        if (hi_run != 3) bad_gaps++;
      end
      hi_run = 0;
    end
    if (cken) begin
      ck_run++;
      if (ck_run > ck_max) ck_max = ck_run;
    end else ck_run = 0;
    if (valid) valid_cnt++;
  end

  initial begin
    int ok, n, v0, g0, b0, f0;
    rst_n = 1'b0; start = 1'b1; start2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_cken", cken, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_data_a", data_a, 0);
    check("rst_data_b", data_b, 0);
    check("rst_overrun", ovr, 0);
    start = 1'b0; start2 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Single frame with default timing
    v0 = valid_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cssu_cs_n", cs_n, 0);
    check("cssu_busy", busy, 1);
    check("cssu_cken", cken, 0);
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (cken === 1'b1 && cs_n === 1'b0 && valid === 1'b0) ok++;
    end
    check("cken_16_cycles", ok, 16);
    @(negedge clk);
    check("s16_cken_off", cken, 0);
    check("s16_cs_low", cs_n, 0);
    @(negedge clk);
    check("s17_no_valid", valid, 0);
    @(negedge clk);
    check("s18_valid", valid, 1);
    check("s18_cs_n_high", cs_n, 1);
    check("s18_data_a", data_a, 14'h2AAA);
    check("s18_data_b", data_b, 14'h1555);
    check("s18_busy", busy, 1);
    @(negedge clk);
    check("s19_valid_low", valid, 0);
    check("s19_quiet_busy", busy, 1);
    @(negedge clk);
    check("s20_idle", busy, 0);
    check("one_valid_pulse", valid_cnt - v0, 1);
    repeat (3) @(negedge clk);
    check("data_hold_a", data_a, 14'h2AAA);

    // Start held high: back-to-back frames
    start = 1'b1;
    n = 0;
    while (cs_n !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    check("held_first_frame", cs_n, 0);
    @(negedge clk);
    v0 = valid_cnt; g0 = gaps; b0 = bad_gaps; f0 = cs_falls;
    repeat (66) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    check("held_back_to_idle", busy, 0);
    @(negedge clk);
    check("held_gap_seen", (gaps - g0) >= 2, 1);
    check("held_gap_len3", bad_gaps - b0, 0);
    check("held_valid_per_frame", valid_cnt - v0, cs_falls - f0 + 1);
    check("held_cken_max16", ck_max, 16);
    check("held_data_a", data_a, 14'h2AAA);

    // Reset inside SHIFT
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst2_data_a", data_a, 0);
    v0 = valid_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    repeat (7) @(negedge clk);
    check("pre_abort_cken", cken, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cs_n", cs_n, 1);
    check("abort_cken", cken, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_valid", valid_cnt - v0, 0);
    check("abort_data_a", data_a, 0);
    check("abort_data_b", data_b, 0);
    check("abort_stays_idle", busy, 0);

    // Slow instance: CS_SETUP_CYC=3, SAMPLE_DELAY=4
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    ok = 0;
    for (int i = 0; i < 3; i++) begin
      if (cs_n2 === 1'b0 && cken2 === 1'b0) ok++;
      @(negedge clk);
    end
    check("dut2_cssu_3", ok, 3);
    check("dut2_cken_at_s", cken2, 1);
    n = 0;
    while (valid2 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("dut2_valid_at_s20", n, 20);
    check("dut2_data_a", data_a2, 14'h329D);
    check("dut2_data_b", data_b2, 14'h0F0F);
    check("dut2_cs_n_at_valid", cs_n2, 1);
    check("dut2_overrun_clear", ovr2, 0);

    // Start while busy
    v0 = valid_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("ovr_frame_valid", valid, 1);
    check("ovr_frame_data_b", data_b, 14'h1555);
    check("ovr_flag", ovr, ExpOvr);
    repeat (8) @(negedge clk);
    check("ovr_no_relaunch", busy, 0);
    check("ovr_single_valid", valid_cnt - v0, 1);
    check("ovr_flag_sticky", ovr, ExpOvr);
    rst_n = 1'b0;
    @(negedge clk);
    check("ovr_cleared_by_rst", ovr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
